// File: rtl/mov_ctrl.sv
// mov_ctrl: sequencer for the register-to-register move datapath.
// Each word takes three cycles: a register-file read, a capture into the
// mover operand register, and a write-back of the mover result. Overlapping
// ranges are handled like memmove. When the destination lies above the
// source, the copy runs from the top of the range downwards.
module mov_ctrl #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [CNT_W-1:0]  cmd_len,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic [DATA_W-1:0] mv_a,
    input  logic [DATA_W-1:0] mv_res,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] src_ptr_q;
    logic [ADDR_W-1:0] dst_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              desc_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] mv_a_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              ready_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic              busy_q;
    logic              done_q;

    logic              desc_d;
    logic [ADDR_W-1:0] len_off_d;
    logic [ADDR_W-1:0] src_start_d;
    logic [ADDR_W-1:0] dst_start_d;
    logic [ADDR_W-1:0] src_next_d;
    logic [ADDR_W-1:0] dst_next_d;

    // Start pointers for a new command and the stepped pointers for the next word.
    always_comb begin
        desc_d      = (cmd_dst > cmd_src);
        len_off_d   = ADDR_W'(cmd_len) - ADDR_W'(1);
        src_start_d = desc_d ? (cmd_src + len_off_d) : cmd_src;
        dst_start_d = desc_d ? (cmd_dst + len_off_d) : cmd_dst;
        src_next_d  = desc_q ? (src_ptr_q - ADDR_W'(1)) : (src_ptr_q + ADDR_W'(1));
        dst_next_d  = desc_q ? (dst_ptr_q - ADDR_W'(1)) : (dst_ptr_q + ADDR_W'(1));
    end

    // Sequencer FSM with registered strobes, addresses and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            cnt_q     <= '0;
            desc_q    <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            mv_a_q    <= '0;
            wr_data_q <= '0;
            ready_q   <= 1'b1;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (cmd_len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_READ;
                            desc_q    <= desc_d;
                            src_ptr_q <= src_start_d;
                            dst_ptr_q <= dst_start_d;
                            cnt_q     <= cmd_len;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= src_start_d;
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_CAPT;
                    rd_en_q <= 1'b0;
                end
                S_CAPT: begin
                    state_q   <= S_WRITE;
                    mv_a_q    <= rf_rd_data;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= dst_ptr_q;
                end
                S_WRITE: begin
                    wr_en_q   <= 1'b0;
                    wr_data_q <= mv_res;
                    src_ptr_q <= src_next_d;
                    dst_ptr_q <= dst_next_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= S_READ;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= src_next_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // During WRITE the mover result passes straight through, and afterwards the last written word is held.
    assign rf_wr_data = wr_en_q ? mv_res : wr_data_q;

    assign cmd_ready  = ready_q;
    assign rf_rd_en   = rd_en_q;
    assign rf_rd_addr = rd_addr_q;
    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = wr_addr_q;
    assign mv_a       = mv_a_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mov_ctrl.sv
// tb_mov_ctrl: directed bench for mov_ctrl with a register-file model and an identity mover.
module tb_mov_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_src;
    logic [3:0]  cmd_dst;
    logic [3:0]  cmd_len;
    logic        rf_rd_en;
    logic [3:0]  rf_rd_addr;
    logic [13:0] rf_rd_data;
    logic [13:0] mv_a;
    logic [13:0] mv_res;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_addr;
    logic [13:0] rf_wr_data;
    logic        busy;
    logic        done;

    mov_ctrl #(.DATA_W(14), .ADDR_W(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .cmd_len    (cmd_len),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .mv_a       (mv_a),
        .mv_res     (mv_res),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Identity mover
    assign mv_res = mv_a;

    // Register-file model plus event logs; cycle index j means the cycle ending at edge j.
    logic [13:0] rf [16];
    logic        pl_en;
    logic [3:0]  pl_addr;
    logic [13:0] pl_data;
    int          ecnt;
    int          both_cnt;
    int          wr_cyc[$];
    int          wr_adr[$];
    int          wr_dat[$];
    int          rd_cyc[$];
    int          rd_adr[$];
    int          dn_cyc[$];
    bit          busy_log [0:4095];
    bit          rdy_log  [0:4095];

    initial begin
        ecnt     = 0;
        both_cnt = 0;
        for (int i = 0; i < 16; i++) rf[i] = '0;
    end

    always @(posedge clk) begin
        if (pl_en) begin
            rf[pl_addr] <= pl_data;
        end else if (rf_wr_en) begin
            rf[rf_wr_addr] <= rf_wr_data;
            wr_cyc.push_back(ecnt + 1);
            wr_adr.push_back(int'(rf_wr_addr));
            wr_dat.push_back(int'(rf_wr_data));
        end
        if (rf_rd_en) begin
            rf_rd_data <= rf[rf_rd_addr];
            rd_cyc.push_back(ecnt + 1);
            rd_adr.push_back(int'(rf_rd_addr));
        end
        if (done) dn_cyc.push_back(ecnt + 1);
        if (rf_rd_en && rf_wr_en) both_cnt <= both_cnt + 1;
        busy_log[(ecnt + 1) % 4096] <= busy;
        rdy_log[(ecnt + 1) % 4096]  <= cmd_ready;
        ecnt <= ecnt + 1;
    end

    int nvec;
    int nerr;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves control at the next negedge.
    task automatic preload(input int a, input int d);
        pl_en   = 1'b1;
        pl_addr = 4'(a);
        pl_data = 14'(d);
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Called at a negedge while idle; returns the accept edge index.
    task automatic issue(input int s, input int d, input int n, output int k);
        cmd_src   = 4'(s);
        cmd_dst   = 4'(d);
        cmd_len   = 4'(n);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        k = ecnt;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, int'(done), 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    int k, r0, w0, d0;

    initial begin
        nvec      = 0;
        nerr      = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = '0;
        pl_en     = 1'b0;
        pl_addr   = '0;
        pl_data   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",   int'(cmd_ready),  1);
        chk("rst_rd_en",   int'(rf_rd_en),   0);
        chk("rst_wr_en",   int'(rf_wr_en),   0);
        chk("rst_busy",    int'(busy),       0);
        chk("rst_done",    int'(done),       0);
        chk("rst_mv_a",    int'(mv_a),       0);
        chk("rst_rd_addr", int'(rf_rd_addr), 0);
        chk("rst_wr_addr", int'(rf_wr_addr), 0);
        chk("rst_wr_data", int'(rf_wr_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word: RF[2]=0x1ABC, src=2 dst=5 len=1
        preload(2, 'h1ABC);
        r0 = rd_cyc.size(); w0 = wr_cyc.size(); d0 = dn_cyc.size();
        issue(2, 5, 1, k);
        wait_done("single", 20);
        chk("single_nrd",    rd_cyc.size() - r0, 1);
        chk("single_rd_cyc", rd_cyc[r0] - k, 1);
        chk("single_rd_adr", rd_adr[r0], 2);
        chk("single_nwr",    wr_cyc.size() - w0, 1);
        chk("single_wr_cyc", wr_cyc[w0] - k, 3);
        chk("single_wr_adr", wr_adr[w0], 5);
        chk("single_wr_dat", wr_dat[w0], 'h1ABC);
        chk("single_dn_cyc", dn_cyc[d0] - k, 4);
        chk("single_busy",   int'(busy_log[k+1] & busy_log[k+2] & busy_log[k+3] & busy_log[k+4] & !busy_log[k+5]), 1);
        chk("single_rdy_dn", int'(rdy_log[k+4]), 0);
        chk("single_rdy_back", int'(rdy_log[k+5]), 1);
        chk("single_rf5",    int'(rf[5]), 'h1ABC);

        // Ascending overlap: src=3 dst=2 len=3
        preload(3, 'h0011);
        preload(4, 'h0022);
        preload(5, 'h0033);
        r0 = rd_cyc.size(); w0 = wr_cyc.size(); d0 = dn_cyc.size();
        issue(3, 2, 3, k);
        wait_done("asc", 40);
        chk("asc_nwr",    wr_cyc.size() - w0, 3);
        chk("asc_wr0",    wr_adr[w0],   2);
        chk("asc_wr1",    wr_adr[w0+1], 3);
        chk("asc_wr2",    wr_adr[w0+2], 4);
        chk("asc_wcyc0",  wr_cyc[w0] - k,   3);
        chk("asc_wcyc2",  wr_cyc[w0+2] - k, 9);
        chk("asc_dn_cyc", dn_cyc[d0] - k, 10);
        chk("asc_rf2",    int'(rf[2]), 'h0011);
        chk("asc_rf3",    int'(rf[3]), 'h0022);
        chk("asc_rf4",    int'(rf[4]), 'h0033);

        // Descending overlap: src=3 dst=4 len=3
        preload(3, 'h0011);
        preload(4, 'h0022);
        preload(5, 'h0033);
        preload(6, 'h0000);
        r0 = rd_cyc.size(); w0 = wr_cyc.size(); d0 = dn_cyc.size();
        issue(3, 4, 3, k);
        wait_done("desc", 40);
        chk("desc_rd0",  rd_adr[r0],   5);
        chk("desc_rd2",  rd_adr[r0+2], 3);
        chk("desc_nwr",  wr_cyc.size() - w0, 3);
        chk("desc_wr0",  wr_adr[w0],   6);
        chk("desc_wr1",  wr_adr[w0+1], 5);
        chk("desc_wr2",  wr_adr[w0+2], 4);
        chk("desc_rf4",  int'(rf[4]), 'h0011);
        chk("desc_rf5",  int'(rf[5]), 'h0022);
        chk("desc_rf6",  int'(rf[6]), 'h0033);

        // Wrap-around: src=14 dst=1 len=4 (ascending). RF[1] is rewritten before it is read.
        preload(14, 'h00A1);
        preload(15, 'h00A2);
        preload(0,  'h00A3);
        preload(1,  'h00A4);
        r0 = rd_cyc.size(); w0 = wr_cyc.size(); d0 = dn_cyc.size();
        issue(14, 1, 4, k);
        wait_done("wrap", 40);
        chk("wrap_nrd", rd_cyc.size() - r0, 4);
        chk("wrap_rd0", rd_adr[r0],   14);
        chk("wrap_rd1", rd_adr[r0+1], 15);
        chk("wrap_rd2", rd_adr[r0+2], 0);
        chk("wrap_rd3", rd_adr[r0+3], 1);
        chk("wrap_wr0", wr_adr[w0],   1);
        chk("wrap_wr1", wr_adr[w0+1], 2);
        chk("wrap_wr2", wr_adr[w0+2], 3);
        chk("wrap_wr3", wr_adr[w0+3], 4);
        chk("wrap_rf2", int'(rf[2]), 'h00A2);
        chk("wrap_rf4", int'(rf[4]), 'h00A1);

        // len=0 followed by len=1 with cmd_valid held high
        preload(5, 'h0155);
        r0 = rd_cyc.size(); w0 = wr_cyc.size(); d0 = dn_cyc.size();
        cmd_src   = 4'd9;
        cmd_dst   = 4'd11;
        cmd_len   = 4'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        k = ecnt;
        cmd_src = 4'd5;
        cmd_dst = 4'd7;
        cmd_len = 4'd1;
        @(posedge clk);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done("b2b", 20);
        chk("b2b_dn0",    dn_cyc[d0] - k, 1);
        chk("b2b_rdy_dn", int'(rdy_log[k+1]), 0);
        chk("b2b_rdy_id", int'(rdy_log[k+2]), 1);
        chk("b2b_nrd",    rd_cyc.size() - r0, 1);
        chk("b2b_rd_cyc", rd_cyc[r0] - k, 3);
        chk("b2b_nwr",    wr_cyc.size() - w0, 1);
        chk("b2b_wr_cyc", wr_cyc[w0] - k, 5);
        chk("b2b_wr_adr", wr_adr[w0], 7);
        chk("b2b_dn1",    dn_cyc[d0+1] - k, 6);
        chk("b2b_rf7",    int'(rf[7]), 'h0155);

        // Reset during the second WRITE of a len=5 command
        preload(0,  'h0000);
        preload(8,  'h0101);
        preload(9,  'h0102);
        preload(10, 'h0103);
        preload(11, 'h0104);
        preload(12, 'h0105);
        w0 = wr_cyc.size(); d0 = dn_cyc.size();
        issue(8, 0, 5, k);
        repeat (6) @(negedge clk);
        chk("mid_in_write2", int'(rf_wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_ready",   int'(cmd_ready),  1);
        chk("mid_rd_en",   int'(rf_rd_en),   0);
        chk("mid_wr_en",   int'(rf_wr_en),   0);
        chk("mid_busy",    int'(busy),       0);
        chk("mid_done",    int'(done),       0);
        chk("mid_mv_a",    int'(mv_a),       0);
        chk("mid_rd_addr", int'(rf_rd_addr), 0);
        chk("mid_wr_addr", int'(rf_wr_addr), 0);
        chk("mid_wr_data", int'(rf_wr_data), 0);
        repeat (3) @(negedge clk);
        chk("mid_nwr_ok",  int'((wr_cyc.size() - w0) >= 1 && (wr_cyc.size() - w0) <= 2), 1);
        chk("mid_rf0",     int'(rf[0]), 'h0101);
        chk("mid_no_done", dn_cyc.size() - d0, 0);
        rst_n = 1'b1;
        #1;
        chk("post_ready",  int'(cmd_ready), 1);
        @(negedge clk);
        d0 = dn_cyc.size();
        issue(10, 13, 1, k);
        wait_done("post", 20);
        chk("post_dn_cyc", dn_cyc[d0] - k, 4);
        chk("post_rf13",   int'(rf[13]), 'h0103);

        chk("no_rd_wr_overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mov_ctrl.md
# mov_ctrl

Sequencer for the 14-bit register-to-register move datapath. It accepts MOV/block-MOV commands from the instruction decoder over a valid/ready handshake. For each word it reads the register file, presents the word to the combinational mover, and writes the mover result back. It sits between the decoder and the register file and handles overlapping source/destination ranges the way memmove does.

## Interface

Parameters:

- DATA_W, 14, word width of register file and mover
- ADDR_W, 4, register-file address width; addresses wrap modulo 2^ADDR_W
- CNT_W, 4, width of the word-count field

Ports:

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  decoder has a command
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_src  in  ADDR_W  first source register
- cmd_dst  in  ADDR_W  first destination register
- cmd_len  in  CNT_W  number of words to move; 0 is a no-op
- rf_rd_en  out  1  register-file read strobe; data returns the next cycle
- rf_rd_addr  out  ADDR_W  read address
- rf_rd_data  in  DATA_W  read data, valid the cycle after rf_rd_en
- mv_a  out  DATA_W  registered operand driven into the mover input
- mv_res  in  DATA_W  combinational mover result
- rf_wr_en  out  1  register-file write strobe
- rf_wr_addr  out  ADDR_W  write address
- rf_wr_data  out  DATA_W  write data, equal to mv_res during WRITE
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when a command completes

## Operation

- FSM states: IDLE, READ, CAPT, WRITE, DONE.
- IDLE: cmd_ready=1. A command is accepted on a rising edge where cmd_valid && cmd_ready.
  - If cmd_len==0, go to DONE.
  - Otherwise latch pointers and count, then go to READ.
- Direction is decided at accept time.
  - Descending when cmd_dst > cmd_src (unsigned compare). Start pointers are src+len-1 and dst+len-1, taken mod 2^ADDR_W. Pointers decrement.
  - Otherwise ascending. Start pointers are src and dst. Pointers increment.
  - src==dst is ascending; the words are rewritten in place.
- READ: rf_rd_en=1, rf_rd_addr=src pointer. Next state CAPT.
- CAPT: mv_a <= rf_rd_data at the end of the cycle. Next state WRITE.
- WRITE:
  - rf_wr_en=1, rf_wr_addr=dst pointer, rf_wr_data=mv_res.
  - Both pointers step, modulo 2^ADDR_W. Remaining count decrements.
  - If the remaining count was 1, go to DONE; otherwise go to READ.
- DONE: done=1 for one cycle. Next state IDLE.
- cmd_src, cmd_dst and cmd_len are sampled only at accept. Later changes on these inputs are ignored.
- rf_rd_addr, rf_wr_addr and rf_wr_data hold their last values when their strobes are low. Verification checks them only while the strobes are high.
- mv_a holds its value between captures.

## Timing

- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - cmd_ready=1.
  - rf_rd_en=0, rf_wr_en=0, busy=0, done=0.
  - mv_a=0, rf_rd_addr=0, rf_wr_addr=0, rf_wr_data=0.
  - Pointers and count are cleared.
- Reset asserted mid-command aborts the command immediately. No further writes occur. Register-file contents already written stay written. There is no done pulse.
- Per word: 3 cycles (READ, CAPT, WRITE).
- A command of N≥1 words, accepted at edge k:
  - READ occupies cycle k+1.
  - The first write is at edge k+3.
  - The last write is at edge k+3N.
  - done is high in cycle k+3N+1.
  - cmd_ready returns high at k+3N+2.
- A len==0 command accepted at edge k produces done in cycle k+1, with no rf strobes.
- Back-to-back commands: minimum gap is one IDLE cycle after DONE. cmd_ready is never high in DONE.
- rf_rd_en and rf_wr_en are never high in the same cycle.

## Test plan

- Single word: RF[2]=0x1ABC; cmd src=2, dst=5, len=1 accepted at edge k.
  - Required: rf_rd_en at k+1 with addr 2.
  - Required: write of 0x1ABC to addr 5 at edge k+3.
  - Required: done in cycle k+4. busy is high from k+1 through k+4.
- Ascending overlap: RF[3..5]=0x0011,0x0022,0x0033; src=3, dst=2, len=3.
  - Required: RF[2..4]=0x0011,0x0022,0x0033.
  - Required: write addresses occur in the order 2,3,4.
- Descending overlap: same initial data; src=3, dst=4, len=3.
  - Required: write addresses occur in the order 6,5,4.
  - Required: RF[4..6]=0x0011,0x0022,0x0033, with no source word corrupted before it is read.
- Wrap-around: src=14, dst=1, len=4, ascending.
  - Required: reads from 14,15,0,1.
  - Required: writes to 1,2,3,4 respectively.
- len=0 and back-to-back: a len=0 command followed by a len=1 command with cmd_valid held high.
  - Required: the first command produces done one cycle after accept, with no strobes.
  - Required: the second command is accepted on the first IDLE edge after that.
- Reset mid-operation: a len=5 command; assert rst_n=0 asynchronously during the second WRITE.
  - Required: all outputs immediately take their reset values.
  - Required: only 1–2 words are written, and no done pulse occurs.
  - Required: after release, cmd_ready=1 and a new command completes normally.
